send_queue_arbiter: RTL and testbench

SEND_QUEUE_ARBITER -- requirements
Module: send_queue_arbiter

---
 rtl/send_queue_arbiter.sv | 151 +++++++++++++++
 tb/tb_send_queue_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_queue_arbiter.sv
// ============================================================================
// send_queue_arbiter
//   Byte/word requester arbitration into a 512-slot circular send queue.
//   Rev 1.0
// ============================================================================
`default_nettype none

module send_queue_arbiter (
    input  logic        CLK,
    input  logic        INITIALIZE,
    input  logic        byte_req,
    input  logic [7:0]  byte_data,
    output logic        byte_ack,
    input  logic        word_req,
    input  logic [31:0] word_data,
    output logic        word_ack,
    input  logic [8:0]  queue_s,
    output logic [8:0]  queue_t,
    output logic        wr_en,
    output logic [8:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        full,
    output logic        empty
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WORD = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [1:0]  idx, idx_next;
    logic [31:0] word_buf, word_buf_next;
    logic        last_word, last_word_next;

    logic        wr_en_next;
    logic [8:0]  wr_addr_next;
    logic [7:0]  wr_data_next;
    logic        byte_ack_next;
    logic        word_ack_next;

    logic [8:0]  used;
    logic [8:0]  eff_tail;
    logic [8:0]  free;
    logic        byte_elig;
    logic        word_elig;
    logic        grant_byte;
    logic        grant_word;
    logic [1:0]  idx_inc;
    logic [7:0]  word_byte;

    assign used  = queue_t - queue_s;
    assign full  = (used == 9'd511);
    assign empty = (used == 9'd0);

    // A write in flight this cycle already owns the slot at queue_t.
    assign eff_tail = queue_t + {8'd0, wr_en};
    assign free     = 9'd511 - (eff_tail - queue_s);

    assign byte_elig = byte_req && !byte_ack && (free >= 9'd1);
    assign word_elig = word_req && !word_ack && (free >= 9'd4);

    assign grant_word = (state == IDLE) && word_elig && (!byte_elig || !last_word);
    assign grant_byte = (state == IDLE) && byte_elig && !grant_word;

    assign idx_inc = idx + 2'd1;

    always_comb begin
        word_byte = word_buf[31:24];
        case (idx_inc)
            2'd1:    word_byte = word_buf[23:16];
            2'd2:    word_byte = word_buf[15:8];
            2'd3:    word_byte = word_buf[7:0];
            default: word_byte = word_buf[31:24];
        endcase
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        word_buf_next  = word_buf;
        last_word_next = last_word;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        byte_ack_next  = 1'b0;
        word_ack_next  = 1'b0;

        case (state)
            IDLE: begin
                if (grant_word) begin
                    word_ack_next  = 1'b1;
                    word_buf_next  = word_data;
                    wr_en_next     = 1'b1;
                    wr_addr_next   = eff_tail;
                    wr_data_next   = word_data[31:24];
                    idx_next       = 2'd0;
                    last_word_next = 1'b1;
                    state_next     = WORD;
                end else if (grant_byte) begin
                    byte_ack_next  = 1'b1;
                    wr_en_next     = 1'b1;
                    wr_addr_next   = eff_tail;
                    wr_data_next   = byte_data;
                    last_word_next = 1'b0;
                end
            end
            WORD: begin
                // idx names the word byte being written this cycle.
                if (idx == 2'd3) begin
                    state_next = IDLE;
                end else begin
                    idx_next     = idx_inc;
                    wr_en_next   = 1'b1;
                    wr_addr_next = eff_tail;
                    wr_data_next = word_byte;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            state     <= IDLE;
            idx       <= 2'd0;
            word_buf  <= 32'd0;
            last_word <= 1'b1;
            queue_t   <= 9'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 9'd0;
            wr_data   <= 8'd0;
            byte_ack  <= 1'b0;
            word_ack  <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            word_buf  <= word_buf_next;
            last_word <= last_word_next;
            queue_t   <= eff_tail;
            wr_en     <= wr_en_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            byte_ack  <= byte_ack_next;
            word_ack  <= word_ack_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_send_queue_arbiter.sv
// ============================================================================
// tb_send_queue_arbiter
//   Directed vector table plus hand-written corner sequences.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_send_queue_arbiter;

    logic        CLK;
    logic        INITIALIZE;
    logic        byte_req;
    logic [7:0]  byte_data;
    logic        byte_ack;
    logic        word_req;
    logic [31:0] word_data;
    logic        word_ack;
    logic [8:0]  queue_s;
    logic [8:0]  queue_t;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;

    int compared;
    int mismatched;

    send_queue_arbiter dut (
        .CLK        (CLK),
        .INITIALIZE (INITIALIZE),
        .byte_req   (byte_req),
        .byte_data  (byte_data),
        .byte_ack   (byte_ack),
        .word_req   (word_req),
        .word_data  (word_data),
        .word_ack   (word_ack),
        .queue_s    (queue_s),
        .queue_t    (queue_t),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        init;
        logic        breq;
        logic [7:0]  bdata;
        logic        wreq;
        logic [31:0] wdata;
        logic [8:0]  qs;
        logic        e_wr_en;
        logic [8:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_back;
        logic        e_wack;
        logic [8:0]  e_qt;
        logic        e_full;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic init, input logic breq, input logic [7:0] bdata,
                                input logic wreq, input logic [31:0] wdata, input logic [8:0] qs,
                                input logic e_wr_en, input logic [8:0] e_addr, input logic [7:0] e_data,
                                input logic e_back, input logic e_wack, input logic [8:0] e_qt,
                                input logic e_full, input logic e_empty);
        vec_t v;
        v.init = init; v.breq = breq; v.bdata = bdata; v.wreq = wreq; v.wdata = wdata; v.qs = qs;
        v.e_wr_en = e_wr_en; v.e_addr = e_addr; v.e_data = e_data; v.e_back = e_back;
        v.e_wack = e_wack; v.e_qt = e_qt; v.e_full = e_full; v.e_empty = e_empty;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_wr(input string name, input logic en, input logic [8:0] addr,
                          input logic [7:0] data, input logic [8:0] qt);
        chk({name, ".wr_en"},   {31'd0, wr_en}, {31'd0, en});
        chk({name, ".wr_addr"}, {23'd0, wr_addr}, {23'd0, addr});
        chk({name, ".wr_data"}, {24'd0, wr_data}, {24'd0, data});
        chk({name, ".queue_t"}, {23'd0, queue_t}, {23'd0, qt});
    endtask

    task automatic do_reset();
        INITIALIZE = 1'b1;
        byte_req   = 1'b0;
        word_req   = 1'b0;
        step();
        INITIALIZE = 1'b0;
    endtask

    // Two cycles per byte: request/ack, then drop the request.
    task automatic fill_bytes(input int n, inout int missing_acks);
        for (int i = 0; i < n; i++) begin
            byte_req  = 1'b1;
            byte_data = i[7:0];
            step();
            if (byte_ack !== 1'b1) missing_acks++;
            byte_req = 1'b0;
            step();
        end
    endtask

    initial begin
        int miss;
        int wack_count;
        compared   = 0;
        mismatched = 0;
        INITIALIZE = 1'b1;
        byte_req   = 1'b0;
        byte_data  = 8'h00;
        word_req   = 1'b0;
        word_data  = 32'h0;
        queue_s    = 9'd0;
        #1;

        // Single byte from reset; reset beats a concurrent request.
        vecs.push_back(mk(1, 1, 8'h41, 0, 32'h0, 0,  0, 0, 8'h00, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h41, 0, 32'h0, 0,  1, 0, 8'h41, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 32'h0, 0,  0, 0, 8'h41, 0, 0, 1, 0, 0));
        // Both requesters held: byte, word, byte, word with atomic words.
        vecs.push_back(mk(1, 0, 8'h00, 0, 32'h0,        0, 0, 0, 8'h00, 0, 0, 0,  0, 1));
        vecs.push_back(mk(0, 1, 8'h11, 1, 32'hA1B2C3D4, 0, 1, 0, 8'h11, 1, 0, 0,  0, 1));
        vecs.push_back(mk(0, 1, 8'h22, 1, 32'hA1B2C3D4, 0, 1, 1, 8'hA1, 0, 1, 1,  0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 1, 32'h55667788, 0, 1, 2, 8'hB2, 0, 0, 2,  0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 1, 32'h55667788, 0, 1, 3, 8'hC3, 0, 0, 3,  0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 1, 32'h55667788, 0, 1, 4, 8'hD4, 0, 0, 4,  0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 1, 32'h55667788, 0, 0, 4, 8'hD4, 0, 0, 5,  0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 1, 32'h55667788, 0, 1, 5, 8'h22, 1, 0, 5,  0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 1, 32'h55667788, 0, 1, 6, 8'h55, 0, 1, 6,  0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 1, 32'h55667788, 0, 1, 7, 8'h66, 0, 0, 7,  0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 1, 32'h55667788, 0, 1, 8, 8'h77, 0, 0, 8,  0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 1, 32'h55667788, 0, 1, 9, 8'h88, 0, 0, 9,  0, 0));
        vecs.push_back(mk(0, 0, 8'h33, 0, 32'h55667788, 0, 0, 9, 8'h88, 0, 0, 10, 0, 0));

        foreach (vecs[i]) begin
            INITIALIZE = vecs[i].init;
            byte_req   = vecs[i].breq;
            byte_data  = vecs[i].bdata;
            word_req   = vecs[i].wreq;
            word_data  = vecs[i].wdata;
            queue_s    = vecs[i].qs;
            step();
            chk($sformatf("vec%0d.wr_en", i),    {31'd0, wr_en},    {31'd0, vecs[i].e_wr_en});
            chk($sformatf("vec%0d.wr_addr", i),  {23'd0, wr_addr},  {23'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d.wr_data", i),  {24'd0, wr_data},  {24'd0, vecs[i].e_data});
            chk($sformatf("vec%0d.byte_ack", i), {31'd0, byte_ack}, {31'd0, vecs[i].e_back});
            chk($sformatf("vec%0d.word_ack", i), {31'd0, word_ack}, {31'd0, vecs[i].e_wack});
            chk($sformatf("vec%0d.queue_t", i),  {23'd0, queue_t},  {23'd0, vecs[i].e_qt});
            chk($sformatf("vec%0d.full", i),     {31'd0, full},     {31'd0, vecs[i].e_full});
            chk($sformatf("vec%0d.empty", i),    {31'd0, empty},    {31'd0, vecs[i].e_empty});
        end

        // Word at tail 5 on an empty queue.
        queue_s = 9'd0;
        do_reset();
        miss = 0;
        fill_bytes(5, miss);
        chk("w5.fill_acks", miss, 0);
        queue_s = 9'd5;
        #1;
        chk("w5.empty", {31'd0, empty}, 32'd1);
        word_req   = 1'b1;
        word_data  = 32'hDEADBEEF;
        wack_count = 0;
        step();
        if (word_ack === 1'b1) wack_count++;
        chk_wr("w5.b0", 1, 9'd5, 8'hDE, 9'd5);
        word_req  = 1'b0;
        word_data = 32'h0;
        step();
        if (word_ack === 1'b1) wack_count++;
        chk_wr("w5.b1", 1, 9'd6, 8'hAD, 9'd6);
        step();
        if (word_ack === 1'b1) wack_count++;
        chk_wr("w5.b2", 1, 9'd7, 8'hBE, 9'd7);
        step();
        if (word_ack === 1'b1) wack_count++;
        chk_wr("w5.b3", 1, 9'd8, 8'hEF, 9'd8);
        step();
        if (word_ack === 1'b1) wack_count++;
        chk_wr("w5.done", 0, 9'd8, 8'hEF, 9'd9);
        chk("w5.word_ack_count", wack_count, 1);

        // Near-full wrap: word held for space while bytes proceed.
        queue_s = 9'd0;
        do_reset();
        miss = 0;
        fill_bytes(510, miss);
        chk("wrap.fill_acks", miss, 0);
        chk("wrap.queue_t", {23'd0, queue_t}, 32'd510);
        queue_s   = 9'd1;
        word_req  = 1'b1;
        word_data = 32'h01020304;
        step();
        chk("wrap.word_held", {31'd0, word_ack | wr_en}, 32'd0);
        byte_req  = 1'b1;
        byte_data = 8'hB0;
        step();
        chk("wrap.b0_ack", {30'd0, byte_ack, word_ack}, 32'd2);
        chk_wr("wrap.b0", 1, 9'd510, 8'hB0, 9'd510);
        byte_data = 8'hB1;
        step();
        chk_wr("wrap.gap", 0, 9'd510, 8'hB0, 9'd511);
        chk("wrap.gap_acks", {30'd0, byte_ack, word_ack}, 32'd0);
        step();
        chk("wrap.b1_ack", {30'd0, byte_ack, word_ack}, 32'd2);
        chk_wr("wrap.b1", 1, 9'd511, 8'hB1, 9'd511);
        byte_req = 1'b0;
        step();
        chk_wr("wrap.wrapped", 0, 9'd511, 8'hB1, 9'd0);
        chk("wrap.full", {31'd0, full}, 32'd1);
        chk("wrap.word_still_held", {31'd0, word_ack}, 32'd0);
        queue_s = 9'd5;
        step();
        chk("wrap.word_ack", {31'd0, word_ack}, 32'd1);
        chk_wr("wrap.w0", 1, 9'd0, 8'h01, 9'd0);
        word_req = 1'b0;
        step();
        chk_wr("wrap.w1", 1, 9'd1, 8'h02, 9'd1);

        // Reset in the middle of a word aborts it.
        queue_s = 9'd0;
        do_reset();
        word_req  = 1'b1;
        word_data = 32'hCAFEF00D;
        step();
        chk("abort.word_ack", {31'd0, word_ack}, 32'd1);
        chk_wr("abort.w0", 1, 9'd0, 8'hCA, 9'd0);
        word_req = 1'b0;
        step();
        chk_wr("abort.w1", 1, 9'd1, 8'hFE, 9'd1);
        INITIALIZE = 1'b1;
        step();
        chk_wr("abort.reset", 0, 9'd0, 8'h00, 9'd0);
        INITIALIZE = 1'b0;
        byte_req   = 1'b1;
        byte_data  = 8'h77;
        step();
        chk("abort.byte_ack", {31'd0, byte_ack}, 32'd1);
        chk_wr("abort.byte", 1, 9'd0, 8'h77, 9'd0);
        byte_req = 1'b0;
        step();
        chk_wr("abort.idle", 0, 9'd0, 8'h77, 9'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
